// File: rtl/fifo_tx_pkg.sv
// Shared types and sizing helpers for the FIFO-fed serial transmitter.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // A single-value counter still needs one flop.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_DATA_W       = 4;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_PARITY_EN    = 1;

  localparam int BAUD_W     = cnt_w(DEF_CLKS_PER_BIT);
  localparam int BIT_W      = $clog2(DEF_DATA_W + 1);
  localparam int FRAME_BITS = DEF_DATA_W + 2 + DEF_PARITY_EN;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read port plus serial-line status bundle between the transmitter and its surroundings.
interface fifo_serial_tx_if #(parameter int DATA_W = 4);
  logic              enable;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              tx_serial;
  logic              busy;
  logic              done;

  modport master (input enable, fifo_empty, fifo_data,
                  output fifo_rd_en, tx_serial, busy, done);
  modport slave  (output enable, fifo_empty, fifo_data,
                  input fifo_rd_en, tx_serial, busy, done);
endinterface

// File: rtl/fifo_serial_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running and flags the last cycle of each bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 2
) (
  input  logic clk,
  input  logic rst_a,
  input  logic clr,
  input  logic run,
  output logic bit_end
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a)        cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (run)     cnt <= bit_end ? '0 : cnt + CNT_W'(1);
  end
endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from sync_fifo and sends each as start / data LSB-first / optional even parity / stop.
// state  | meaning
// IDLE   | line high, waiting for enable and a non-empty FIFO
// READ   | one-cycle pop request
// LOAD   | capture popped word, compute parity, clear counters
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even-parity bit
// STOP   | stop bit (high); may chain straight into READ
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_a,
  fifo_serial_tx_if.master  bus
);
  localparam int BAUD_CW = cnt_w(CLKS_PER_BIT);
  localparam int BIT_CW  = $clog2(DATA_W + 1);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   shift;
  logic [BIT_CW-1:0]   bit_cnt;
  logic                parity;
  logic                bit_end, run, clr, load, shift_en;
  logic                rd_en, tx, done;
  logic                last_bit, start_ok;

  assign run      = (state == ST_START) || (state == ST_DATA) ||
                    (state == ST_PARITY) || (state == ST_STOP);
  assign last_bit = (bit_cnt == BIT_CW'(DATA_W - 1));
  assign start_ok = bus.enable && !bus.fifo_empty;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(BAUD_CW)) u_baud (
    .clk     (clk),
    .rst_a   (rst_a),
    .clr     (clr),
    .run     (run),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    tx       = 1'b1;
    done     = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state)
      ST_IDLE:   if (start_ok) state_nx = ST_READ;
      ST_READ: begin
        rd_en    = 1'b1;
        state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        load     = 1'b1;
        clr      = 1'b1;
        state_nx = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_end) state_nx = ST_DATA;
      end
      ST_DATA: begin
        tx = shift[0];
        if (bit_end) begin
          shift_en = 1'b1;
          if (last_bit) state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        tx = parity;
        if (bit_end) state_nx = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          done     = 1'b1;
          state_nx = start_ok ? ST_READ : ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      shift   <= '0;
      bit_cnt <= '0;
      parity  <= 1'b0;
    end else if (load) begin
      shift   <= bus.fifo_data;
      bit_cnt <= '0;
      parity  <= ^bus.fifo_data;
    end else if (shift_en) begin
      shift   <= shift >> 1;
      bit_cnt <= bit_cnt + BIT_CW'(1);
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.tx_serial  = tx;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = done;
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-backed FIFO, table vectors, random words vs a frame model, corner sequences.
module tb_fifo_serial_tx;
  import fifo_tx_pkg::*;

  localparam int CPB_A = 4;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  always #5 clk = ~clk;

  fifo_serial_tx_if #(.DATA_W(4)) ifa ();
  fifo_serial_tx_if #(.DATA_W(4)) ifb ();

  fifo_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB_A), .PARITY_EN(1)) dut_a (
    .clk(clk), .rst_a(rst_a), .bus(ifa.master));
  fifo_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst_a(rst_a), .bus(ifb.master));

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  logic [3:0] fifo_q[$];

  typedef struct {
    logic [3:0] word;
    logic [6:0] bits;   // bits[0] goes out first
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: pops on the cycle rd_en is seen, data valid for the following cycle.
  always @(negedge clk) begin
    checks++;
    if (ifa.fifo_rd_en && ifa.fifo_empty) begin
      errors++;
      $display("FAIL rd_while_empty: fifo_rd_en=1 with fifo_empty=1 at %0t", $time);
    end
    if (ifa.fifo_rd_en) begin
      rd_count++;
      if (fifo_q.size() > 0) ifa.fifo_data = fifo_q.pop_front();
    end
    ifa.fifo_empty = (fifo_q.size() == 0);
  end

  function automatic logic [15:0] model_bits(input logic [3:0] w, input int par_en);
    logic [15:0] b;
    int pos, ones;
    b = '0; pos = 0; ones = 0;
    b[pos] = 1'b0; pos++;
    for (int i = 0; i < 4; i++) begin
      b[pos] = w[i]; pos++;
      if (w[i]) ones++;
    end
    if (par_en != 0) begin
      b[pos] = ((ones % 2) == 1); pos++;
    end
    b[pos] = 1'b1;
    return b;
  endfunction

  task automatic wait_rd(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ifa.fifo_rd_en) ok = 1;
    end
    chk({name, " rd_timeout"}, ok, 1'b1);
  endtask

  // Entered at the negedge of the READ cycle; returns at the negedge of the last STOP cycle.
  task automatic check_frame(input string name, input logic [15:0] bits, input int nbits);
    chk({name, " read_busy"}, ifa.busy, 1'b1);
    chk({name, " read_tx"}, ifa.tx_serial, 1'b1);
    @(negedge clk);
    chk({name, " load_rd"}, ifa.fifo_rd_en, 1'b0);
    chk({name, " load_tx"}, ifa.tx_serial, 1'b1);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB_A; c++) begin
        @(negedge clk);
        chk($sformatf("%s tx_bit%0d", name, b), ifa.tx_serial, bits[b]);
        chk($sformatf("%s done_bit%0d", name, b), ifa.done, (b == nbits - 1) && (c == CPB_A - 1));
        chk($sformatf("%s busy_bit%0d", name, b), ifa.busy, 1'b1);
        chk($sformatf("%s rd_bit%0d", name, b), ifa.fifo_rd_en, 1'b0);
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk({name, " busy"}, ifa.busy, 1'b0);
    chk({name, " tx"}, ifa.tx_serial, 1'b1);
  endtask

  logic [3:0] rw[6];
  logic [3:0] bw;
  int rc, cyc;
  bit okb;

  initial begin
    vecs[0] = '{4'b0101, 7'b1001010};
    vecs[1] = '{4'b0001, 7'b1100010};
    vecs[2] = '{4'b1111, 7'b1011110};
    vecs[3] = '{4'b0000, 7'b1000000};
    vecs[4] = '{4'b1010, 7'b1010100};

    ifa.enable = 1'b1;
    ifb.enable = 1'b0;
    ifb.fifo_empty = 1'b1;
    ifb.fifo_data = 4'b0000;
    fifo_q.push_back(vecs[0].word);

    // Reset held with a word waiting and enable high.
    repeat (3) @(negedge clk);
    chk("rst tx", ifa.tx_serial, 1'b1);
    chk("rst rd_en", ifa.fifo_rd_en, 1'b0);
    chk("rst busy", ifa.busy, 1'b0);
    chk("rst done", ifa.done, 1'b0);
    chk_int("rst rd_count", rd_count, 0);
    rst_a = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (i > 0) fifo_q.push_back(vecs[i].word);
      wait_rd($sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), {9'b0, vecs[i].bits}, FRAME_BITS);
      check_idle($sformatf("vec%0d_after", i));
    end
    chk_int("vec rd_count", rd_count, 5);

    // Back-to-back frames with no idle cycle between them.
    fifo_q.push_back(4'b0001);
    fifo_q.push_back(4'b1111);
    wait_rd("b2b0");
    check_frame("b2b0", {9'b0, vecs[1].bits}, FRAME_BITS);
    @(negedge clk);
    chk("b2b no_idle", ifa.fifo_rd_en, 1'b1);
    check_frame("b2b1", {9'b0, vecs[2].bits}, FRAME_BITS);
    check_idle("b2b_after");

    // Empty FIFO with enable high for 100 ns.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("empty rd_en", ifa.fifo_rd_en, 1'b0);
      chk("empty busy", ifa.busy, 1'b0);
    end

    // Random words streamed back-to-back against the frame model.
    for (int i = 0; i < 6; i++) begin
      rw[i] = 4'($urandom_range(0, 15));
      fifo_q.push_back(rw[i]);
    end
    wait_rd("rand0");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk($sformatf("rand%0d b2b", i), ifa.fifo_rd_en, 1'b1);
      end
      check_frame($sformatf("rand%0d", i), model_bits(rw[i], 1), FRAME_BITS);
    end
    check_idle("rand_after");

    // Enable dropped during DATA: frame completes, the remaining word stays queued.
    fifo_q.push_back(4'b0110);
    fifo_q.push_back(4'b1001);
    wait_rd("endrop");
    fork
      check_frame("endrop", model_bits(4'b0110, 1), FRAME_BITS);
      begin
        repeat (8) @(negedge clk);
        ifa.enable = 1'b0;
      end
    join
    rc = rd_count;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("endrop rd_en", ifa.fifo_rd_en, 1'b0);
      chk("endrop busy", ifa.busy, 1'b0);
    end
    chk_int("endrop rd_count", rd_count, rc);
    chk_int("endrop queued", fifo_q.size(), 1);

    // Reset during DATA: line returns high at once, popped word is lost.
    ifa.enable = 1'b1;
    wait_rd("midrst");
    repeat (10) @(negedge clk);
    chk("midrst pre_tx", ifa.tx_serial, 1'b0);
    #2 rst_a = 1'b1;
    #1;
    chk("midrst tx", ifa.tx_serial, 1'b1);
    chk("midrst busy", ifa.busy, 1'b0);
    chk("midrst rd_en", ifa.fifo_rd_en, 1'b0);
    chk("midrst done", ifa.done, 1'b0);
    @(negedge clk);
    rst_a = 1'b0;
    chk_int("midrst queue", fifo_q.size(), 0);
    check_idle("midrst_after");
    fifo_q.push_back(4'b0111);
    wait_rd("postrst");
    check_frame("postrst", model_bits(4'b0111, 1), FRAME_BITS);
    check_idle("postrst_after");

    // One clock per bit, no parity, word 1010.
    bw = 4'b1010;
    ifb.fifo_data = bw;
    ifb.fifo_empty = 1'b0;
    ifb.enable = 1'b1;
    okb = 0;
    for (int i = 0; i < 50 && !okb; i++) begin
      @(negedge clk);
      if (ifb.fifo_rd_en) okb = 1;
    end
    chk("cfg rd_timeout", okb, 1'b1);
    ifb.fifo_empty = 1'b1;
    cyc = 1;
    chk("cfg read_busy", ifb.busy, 1'b1);
    @(negedge clk);
    cyc++;
    chk("cfg load_tx", ifb.tx_serial, 1'b1);
    chk("cfg load_rd", ifb.fifo_rd_en, 1'b0);
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      cyc++;
      chk($sformatf("cfg tx_bit%0d", b), ifb.tx_serial, model_bits(bw, 0)[b]);
      chk($sformatf("cfg done_bit%0d", b), ifb.done, (b == 5));
    end
    chk_int("cfg frame_len", cyc, 8);
    @(negedge clk);
    chk("cfg idle_busy", ifb.busy, 1'b0);
    chk("cfg idle_tx", ifb.tx_serial, 1'b1);
    chk("cfg idle_rd", ifb.fifo_rd_en, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Read-side consumer for sync_fifo. It pops DATA_W-bit words from the FIFO through the rd_en/empty handshake and transmits each word as a framed serial stream: start bit, data LSB first, optional even parity, then stop bit. It sits between sync_fifo's read port and an off-block serial line. The FIFO write side stays with the producer.

Parameters:
DATA_W, 4, width of the FIFO word and of the serial data field
CLKS_PER_BIT, 4, clock cycles per serial bit (must be >= 1)
PARITY_EN, 1, 1 inserts an even-parity bit after the data; 0 omits it

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_a  input  1  asynchronous reset, active-high
enable  input  1  permits new words to be started; sampled only at frame boundaries
fifo_empty  input  1  sync_fifo empty flag
fifo_data  input  DATA_W  sync_fifo data_out; valid on the cycle after a rd_en cycle
fifo_rd_en  output  1  pop request to sync_fifo; exactly one cycle per word
tx_serial  output  1  serial line; idle high
busy  output  1  high from the READ state through the last STOP cycle
done  output  1  one-cycle pulse in the final STOP cycle of each frame

Behaviour:
- Reset: rst_a=1 forces state IDLE immediately, without waiting for a clock.
  - Outputs under reset: fifo_rd_en=0, tx_serial=1, busy=0, done=0.
  - Shift register, bit counter and baud counter are all cleared to 0.
- States: IDLE, READ, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx_serial=1. If enable && !fifo_empty, go to READ; otherwise stay.
- READ, 1 cycle: fifo_rd_en=1. This is the only state that asserts fifo_rd_en. Next state is LOAD.
- LOAD, 1 cycle:
  - Capture fifo_data into the shift register.
  - Compute parity as the XOR of the captured word.
  - Clear the baud counter and bit counter. Next state is START.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx_serial=shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right after each bit.
  - After DATA_W bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx_serial = XOR of the word (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles. done=1 in the last STOP cycle.
  - In that same cycle: if enable && !fifo_empty, go directly to READ (back-to-back frames). Otherwise go to IDLE.
- Latency and frame length:
  - The first START cycle begins 2 cycles after the READ decision.
  - Frame length = 2 + (DATA_W + 2 + PARITY_EN) * CLKS_PER_BIT cycles. Defaults give 30.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT) with a minimum of 1; it wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter width is clog2(DATA_W+1).
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- Boundaries:
  - fifo_rd_en is never asserted while fifo_empty=1.
  - enable falling mid-frame: the frame completes and no further read is issued.
  - fifo_empty changing mid-frame is ignored.
  - FIFO going empty after the last pop: return to IDLE, tx_serial stays 1.
  - rst_a mid-frame: the frame is aborted and the popped word is discarded. tx_serial returns to 1 asynchronously.
- tx_serial is driven from registered state and shift register only, so it is glitch-free.

Decomposition:
- Package fifo_tx_pkg holds:
  - the state enum (7 states, 3-bit encoding);
  - localparams for the baud and bit counter widths;
  - localparam FRAME_BITS = DATA_W + 2 + PARITY_EN.
- One sub-module, baud_tick_gen: a CLKS_PER_BIT down/up counter that emits a bit_end pulse. It takes rst_a and a sync clear asserted in LOAD.
- FSM, shift register and parity logic stay in the top module.

Test Plan:
1. Reset check: rst_a=1 for 10 ns with fifo_empty=0 and enable=1 -> tx_serial=1, fifo_rd_en=0, busy=0, done=0. No read occurs during reset.
2. Single word with default parameters: FIFO holds 4'b0101, enable=1 -> exactly one fifo_rd_en pulse.
   - tx_serial shows 0, 1, 0, 1, 0, 0, 1, each bit held 4 cycles.
   - done pulses once; the frame totals 30 cycles.
3. Back-to-back words: FIFO holds 4'b0001 then 4'b1111 -> the second READ immediately follows the last STOP cycle with no IDLE cycle.
   - Parity bit is 1 for 4'b0001 and 0 for 4'b1111.
   - FIFO empty afterwards -> IDLE, tx_serial=1.
4. Empty FIFO: fifo_empty=1 with enable=1 for 100 ns -> fifo_rd_en is never asserted, busy=0.
5. Mid-frame events:
   - Drop enable during DATA -> the frame completes; no further read even though fifo_empty=0.
   - Separately, assert rst_a during DATA -> tx_serial=1 and busy=0 asynchronously.
   - After release, the next word transmits cleanly.
6. Configurability: PARITY_EN=0, CLKS_PER_BIT=1, word 4'b1010 -> tx_serial shows 0, 0, 1, 0, 1, 1, one cycle per bit; frame totals 8 cycles.
